irq_ctrl: RTL and testbench

Interrupt controller that terminates the per-peripheral `irq` lines (timer, UART, etc.) and presents one registered interrupt request plus a claimable vector to the CPU. It sits on the same word-wide `stb`/`we`/`ack` I/O bus as the peripherals it serves, and it is the receiving end of their level-sensitive `irq` outputs. Each line is individually masked and individually configured as level- or edge-triggered. Pending edge events are latched until software clears or claims them.

---
 rtl/irq_pkg.sv | 26 ++
 rtl/irq_prio.sv | 25 ++
 rtl/irq_ctrl.sv | 117 +++++++++++
 tb/tb_irq_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt controller register map.
package irq_pkg;

    // Widest supported controller and width of a line index
    localparam int IRQ_NMAX      = 32;
    localparam int IRQ_IDX_W     = 5;

    // Position of the "request present" flag in the VECTOR word
    localparam int IRQ_VEC_VALID = 31;

    // Word register select values on addr
    localparam logic [1:0] IRQ_PEND = 2'd0;
    localparam logic [1:0] IRQ_MASK = 2'd1;
    localparam logic [1:0] IRQ_MODE = 2'd2;
    localparam logic [1:0] IRQ_VEC  = 2'd3;

    // Build the VECTOR read word; the index field is forced to 0 when nothing is active
    function automatic logic [31:0] irq_vec_word(input logic valid, input logic [IRQ_IDX_W-1:0] idx);
        logic [31:0] w;
        w                      = '0;
        w[IRQ_VEC_VALID]       = valid;
        w[IRQ_IDX_W-1:0]       = valid ? idx : '0;
        return w;
    endfunction

endpackage

// File: rtl/irq_prio.sv
// Lowest-index-wins priority encoder over the active interrupt set.
module irq_prio
    import irq_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]         req,
    output logic [IRQ_IDX_W-1:0] idx,
    output logic                 valid
);

    // Scan from the top down so the last hit, the lowest set bit, is the one kept
    always_comb begin
        // NOTE: defaults first so every path assigns idx/valid and no latch is inferred.
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IRQ_IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: samples per-peripheral irq lines, holds edge events,
// masks them, and presents one registered request plus a claimable vector.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stb,
    input  logic         we,
    input  logic [1:0]   addr,
    input  logic [31:0]  data_in,
    output logic [31:0]  data_out,
    output logic         ack,
    input  logic [N-1:0] irq_in,
    output logic         irq_out
);

    logic [N-1:0]         irq_q;
    logic [N-1:0]         epend;
    logic [N-1:0]         mask_q;
    logic [N-1:0]         mode_q;

    logic [N-1:0]         rise;
    logic [N-1:0]         pend;
    logic [N-1:0]         act;
    logic [N-1:0]         claim_clr;
    logic [N-1:0]         w1c_clr;
    logic [N-1:0]         mode_next;
    logic [N-1:0]         epend_next;

    logic [IRQ_IDX_W-1:0] act_idx;
    logic                 act_valid;

    logic                 wr_pend;
    logic                 wr_mask;
    logic                 wr_mode;
    logic                 claim;

    // Upper write-data bits have no register behind them on narrow controllers
    if (N < IRQ_NMAX) begin : g_unused_hi
        logic unused_data_hi;
        assign unused_data_hi = &{1'b0, data_in[IRQ_NMAX-1:N]};
    end

    // Zero-wait-state bus
    assign ack     = stb;
    assign wr_pend = stb & we & (addr == IRQ_PEND);
    assign wr_mask = stb & we & (addr == IRQ_MASK);
    assign wr_mode = stb & we & (addr == IRQ_MODE);

    // Rising edge seen against last cycle's sample
    assign rise = irq_in & ~irq_q;

    // Edge lines report their latched event, level lines report the live sample
    assign pend = (mode_q & epend) | (~mode_q & irq_q);
    assign act  = pend & mask_q;

    irq_prio #(.N(N)) u_prio (
        .req   (act),
        .idx   (act_idx),
        .valid (act_valid)
    );

    // A successful VECTOR read claims the line it reported
    assign claim = stb & ~we & (addr == IRQ_VEC) & act_valid;

    // Decode claim and W1C into per-line clears; only edge lines can be cleared
    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < N; i++) begin
            claim_clr[i] = claim && (act_idx == IRQ_IDX_W'(i));
        end
        claim_clr = claim_clr & mode_q;
        w1c_clr   = wr_pend ? (data_in[N-1:0] & mode_q) : '0;
    end

    // New edge-pending state: a same-cycle rising edge beats any clear, and lines
    // switched to level mode drop their stale event immediately
    always_comb begin
        mode_next  = wr_mode ? data_in[N-1:0] : mode_q;
        epend_next = ((epend & ~(claim_clr | w1c_clr)) | (rise & mode_q)) & mode_next;
    end

    // Register state; a reset edge wins over any access in the same cycle
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            irq_q   <= '0;
            epend   <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            irq_out <= 1'b0;
        end else begin
            irq_q   <= irq_in;
            epend   <= epend_next;
            mask_q  <= wr_mask ? data_in[N-1:0] : mask_q;
            mode_q  <= mode_next;
            irq_out <= |act;
        end
    end

    // Read mux, combinational from addr and current state, zero-extended
    always_comb begin
        data_out = '0;
        case (addr)
            IRQ_PEND: data_out[N-1:0] = pend;
            IRQ_MASK: data_out[N-1:0] = mask_q;
            IRQ_MODE: data_out[N-1:0] = mode_q;
            IRQ_VEC:  data_out        = irq_vec_word(act_valid, act_idx);
            default:  data_out        = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a table of per-cycle bus/irq vectors with
// hand-computed expectations, followed by hand-written multi-cycle corner cases.
module tb_irq_ctrl;
    import irq_pkg::*;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rst_next = 1'b1;
    logic         stb = 1'b0;
    logic         we = 1'b0;
    logic [1:0]   addr = 2'd0;
    logic [31:0]  data_in = '0;
    logic [N-1:0] irq_in = '0;
    logic [31:0]  data_out;
    logic         ack;
    logic         irq_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         stb;
        logic         we;
        logic [1:0]   addr;
        logic [31:0]  din;
        logic [N-1:0] irq;
        logic         chk_do;
        logic [31:0]  exp_do;
        logic         exp_irq;
    } vec_t;

    vec_t vecs[$];

    irq_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .irq_in   (irq_in),
        .irq_out  (irq_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive just after the edge, check mid-cycle before the next edge
    task automatic step(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic [N-1:0] irq, input logic chk_do, input logic [31:0] exp_do,
                        input logic exp_irq, input string name);
        @(posedge clk);
        #1;
        rst     = rst_next;
        stb     = s;
        we      = w;
        addr    = a;
        data_in = d;
        irq_in  = irq;
        #2;
        if (chk_do) check({name, " data_out"}, data_out, exp_do);
        check({name, " irq_out"}, {31'b0, irq_out}, {31'b0, exp_irq});
        check({name, " ack"}, {31'b0, ack}, {31'b0, s});
    endtask

    task automatic rd(input logic [1:0] a, input logic [N-1:0] irq, input logic [31:0] exp_do,
                      input logic exp_irq, input string name);
        step(1'b1, 1'b0, a, 32'h0, irq, 1'b1, exp_do, exp_irq, name);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [N-1:0] irq,
                      input logic exp_irq, input string name);
        step(1'b1, 1'b1, a, d, irq, 1'b0, 32'h0, exp_irq, name);
    endtask

    task automatic idle(input logic [N-1:0] irq, input logic exp_irq, input string name);
        step(1'b0, 1'b0, 2'd0, 32'h0, irq, 1'b0, 32'h0, exp_irq, name);
    endtask

    function automatic vec_t mk(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d,
                                input logic [N-1:0] irq, input logic chk_do, input logic [31:0] exp_do,
                                input logic exp_irq);
        vec_t v;
        v.stb = s; v.we = w; v.addr = a; v.din = d; v.irq = irq;
        v.chk_do = chk_do; v.exp_do = exp_do; v.exp_irq = exp_irq;
        return v;
    endfunction

    initial begin
        // Level line 0
        vecs.push_back(mk(1, 1, IRQ_MASK, 32'h1,  16'h0000, 0, 32'h0,        0));
        vecs.push_back(mk(1, 1, IRQ_MODE, 32'h0,  16'h0000, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, IRQ_PEND, 32'h0,  16'h0001, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, IRQ_PEND, 32'h0,  16'h0001, 1, 32'h1,        0));
        vecs.push_back(mk(1, 0, IRQ_VEC,  32'h0,  16'h0001, 1, 32'h80000000, 1));
        vecs.push_back(mk(1, 0, IRQ_VEC,  32'h0,  16'h0000, 1, 32'h80000000, 1));
        vecs.push_back(mk(0, 0, IRQ_PEND, 32'h0,  16'h0000, 0, 32'h0,        1));
        vecs.push_back(mk(1, 0, IRQ_VEC,  32'h0,  16'h0000, 1, 32'h0,        0));
        // Edge line 3, claimed by VECTOR read
        vecs.push_back(mk(1, 1, IRQ_MODE, 32'h8,  16'h0000, 0, 32'h0,        0));
        vecs.push_back(mk(1, 1, IRQ_MASK, 32'h8,  16'h0000, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, IRQ_PEND, 32'h0,  16'h0008, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, IRQ_PEND, 32'h0,  16'h0000, 1, 32'h8,        0));
        vecs.push_back(mk(1, 0, IRQ_VEC,  32'h0,  16'h0000, 1, 32'h80000003, 1));
        vecs.push_back(mk(1, 0, IRQ_PEND, 32'h0,  16'h0000, 1, 32'h0,        1));
        vecs.push_back(mk(0, 0, IRQ_PEND, 32'h0,  16'h0000, 0, 32'h0,        0));
        // Priority between edge lines 2 and 5
        vecs.push_back(mk(1, 1, IRQ_MODE, 32'h24, 16'h0000, 0, 32'h0,        0));
        vecs.push_back(mk(1, 1, IRQ_MASK, 32'h24, 16'h0000, 0, 32'h0,        0));
        vecs.push_back(mk(0, 0, IRQ_PEND, 32'h0,  16'h0024, 0, 32'h0,        0));
        vecs.push_back(mk(1, 0, IRQ_VEC,  32'h0,  16'h0000, 1, 32'h80000002, 0));
        vecs.push_back(mk(1, 0, IRQ_VEC,  32'h0,  16'h0000, 1, 32'h80000005, 1));
        vecs.push_back(mk(1, 0, IRQ_VEC,  32'h0,  16'h0000, 1, 32'h00000000, 1));
        vecs.push_back(mk(0, 0, IRQ_PEND, 32'h0,  16'h0000, 0, 32'h0,        0));

        // Reset, then reset-state reads
        rst = 1'b1;
        rst_next = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_next = 1'b0;
        rd(IRQ_PEND, '0, 32'h0, 0, "rst pend");
        rd(IRQ_MASK, '0, 32'h0, 0, "rst mask");
        rd(IRQ_MODE, '0, 32'h0, 0, "rst mode");
        rd(IRQ_VEC,  '0, 32'h0, 0, "rst vec");

        foreach (vecs[i]) begin
            step(vecs[i].stb, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].irq,
                 vecs[i].chk_do, vecs[i].exp_do, vecs[i].exp_irq, $sformatf("vec[%0d]", i));
        end

        // Collision: rising edge on line 4 in the same cycle as its W1C
        wr(IRQ_MODE, 32'h10, '0, 0, "col mode");
        wr(IRQ_MASK, 32'h10, '0, 0, "col mask");
        idle(16'h0010, 0, "col pulse");
        rd(IRQ_PEND, '0, 32'h10, 0, "col pend1");
        wr(IRQ_PEND, 32'h10, 16'h0010, 1, "col w1c+edge");
        rd(IRQ_PEND, '0, 32'h10, 1, "col set wins");
        wr(IRQ_PEND, 32'h10, '0, 1, "col w1c");
        rd(IRQ_PEND, '0, 32'h0, 1, "col cleared");
        idle('0, 0, "col drop");

        // Masked edge event, unmasked later, then removed by a switch to level mode
        wr(IRQ_MASK, 32'h0, '0, 0, "mm mask0");
        wr(IRQ_MODE, 32'h2, '0, 0, "mm mode");
        idle(16'h0002, 0, "mm pulse");
        rd(IRQ_PEND, '0, 32'h2, 0, "mm pend");
        idle('0, 0, "mm masked");
        wr(IRQ_MASK, 32'h2, '0, 0, "mm unmask");
        idle('0, 0, "mm wait");
        idle('0, 1, "mm raised");
        wr(IRQ_MODE, 32'h0, '0, 1, "mm level");
        rd(IRQ_PEND, '0, 32'h0, 1, "mm epend clr");
        idle('0, 0, "mm fell");

        // Reset in the middle of a write with pending edges and all lines unmasked
        wr(IRQ_MODE, 32'hFFFF, '0, 0, "rs mode");
        wr(IRQ_MASK, 32'hFFFF, '0, 0, "rs mask");
        idle(16'h00FF, 0, "rs pulse");
        rd(IRQ_PEND, '0, 32'hFF, 0, "rs pend");
        idle('0, 1, "rs raised");
        rst_next = 1'b1;
        wr(IRQ_MASK, 32'h1234, '0, 1, "rs during");
        rst_next = 1'b0;
        rd(IRQ_PEND, '0, 32'h0, 0, "rs2 pend");
        rd(IRQ_MASK, '0, 32'h0, 0, "rs2 mask");
        rd(IRQ_MODE, '0, 32'h0, 0, "rs2 mode");
        rd(IRQ_VEC,  '0, 32'h0, 0, "rs2 vec");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
